// File: rtl/moving_average_inverse_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | moving_average_inverse_pkg: widths, types and helpers for the inverse |
// | moving-average reconstructor.                        Revision: 1.0    |
// +-----------------------------------------------------------------------+
package moving_average_inverse_pkg;

  localparam int SIZE_MAX_WINDOW = 64;
  localparam int SIZE_DATA       = 16;
  localparam int SIZE_PTR        = $clog2(SIZE_MAX_WINDOW);
  localparam int SIZE_SUM        = SIZE_DATA + SIZE_PTR;
  localparam int SIZE_WIN        = SIZE_PTR + 1;
  localparam int SIZE_ACC        = SIZE_SUM + 2;

  typedef logic signed [SIZE_DATA-1:0] data_t;
  typedef logic signed [SIZE_SUM-1:0]  sum_t;
  typedef logic signed [SIZE_ACC-1:0]  acc_t;
  typedef logic [SIZE_PTR-1:0]         ptr_t;
  typedef logic [SIZE_WIN-1:0]         win_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam acc_t C_DATA_MAX = acc_t'((2 ** (SIZE_DATA - 1)) - 1);
  localparam acc_t C_DATA_MIN = acc_t'(-(2 ** (SIZE_DATA - 1)));
  localparam win_t C_WIN_MAX  = win_t'(SIZE_MAX_WINDOW);

  function automatic win_t clamp_window(input win_t ws);
    if (ws == '0) return win_t'(1);
    if (ws > C_WIN_MAX) return C_WIN_MAX;
    return ws;
  endfunction

endpackage
`default_nettype wire

// File: rtl/moving_average_inverse_history_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | moving_average_inverse_history_ram: circular sample history, one      |
// | shared address, read-before-write.                   Revision: 1.0    |
// +-----------------------------------------------------------------------+
module moving_average_inverse_history_ram
  import moving_average_inverse_pkg::*;
(
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [SIZE_PTR-1:0]         addr_i,
  input  logic signed [SIZE_DATA-1:0] wdata_i,
  output logic signed [SIZE_DATA-1:0] rdata_o
);

  data_t mem_q [SIZE_MAX_WINDOW];

  // Asynchronous read sees the contents from before this cycle's write.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/moving_average_inverse.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | moving_average_inverse: rebuilds samples x[n] = S[n]-S[n-1]+x[n-N]    |
// | from a windowed running sum, with saturation.        Revision: 1.0    |
// +-----------------------------------------------------------------------+
module moving_average_inverse
  import moving_average_inverse_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [SIZE_WIN-1:0]         window_size,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SIZE_SUM-1:0]  in_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [SIZE_DATA-1:0] out_data,
  output logic                        overflow
);

  logic   out_valid_q, out_valid_d;
  data_t  out_data_q,  out_data_d;
  logic   overflow_q,  overflow_d;
  sum_t   prev_sum_q,  prev_sum_d;
  ptr_t   wr_ptr_q,    wr_ptr_d;
  win_t   fill_cnt_q,  fill_cnt_d;
  win_t   win_q,       win_d;

  state_t state;
  logic   xfer;
  data_t  hist_rd;
  data_t  old;
  acc_t   diff;
  data_t  sat;
  logic   clamped;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready && !clear;
  assign state    = (fill_cnt_q < win_q) ? ST_FILL : ST_RUN;
  assign old      = (state == ST_FILL) ? '0 : hist_rd;
  assign diff     = acc_t'(in_sum) - acc_t'(prev_sum_q) + acc_t'(old);

  always_comb begin
    sat     = diff[SIZE_DATA-1:0];
    clamped = 1'b0;
    if (diff > C_DATA_MAX) begin
      sat     = {1'b0, {(SIZE_DATA-1){1'b1}}};
      clamped = 1'b1;
    end else if (diff < C_DATA_MIN) begin
      sat     = {1'b1, {(SIZE_DATA-1){1'b0}}};
      clamped = 1'b1;
    end
  end

  moving_average_inverse_history_ram u_hist (
    .clk     (clk),
    .we_i    (xfer),
    .addr_i  (wr_ptr_q),
    .wdata_i (sat),
    .rdata_o (hist_rd)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    prev_sum_d  = prev_sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    win_d       = win_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sat;
      overflow_d  = overflow_q | clamped;
      prev_sum_d  = in_sum;
      wr_ptr_d    = ({1'b0, wr_ptr_q} == win_q - win_t'(1)) ? '0 : wr_ptr_q + ptr_t'(1);
      if (state == ST_FILL) begin
        fill_cnt_d = fill_cnt_q + win_t'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // History needs no flush: FILL forces old=0 until every slot in the window is rewritten.
    if (clear) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      prev_sum_d  = '0;
      wr_ptr_d    = '0;
      fill_cnt_d  = '0;
      win_d       = clamp_window(window_size);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      prev_sum_q  <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      win_q       <= clamp_window(window_size);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      prev_sum_q  <= prev_sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      win_q       <= win_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_average_inverse.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_moving_average_inverse: directed vectors and sum-encoded streams   |
// | for the inverse moving-average block.                Revision: 1.0    |
// +-----------------------------------------------------------------------+
module tb_moving_average_inverse;
  import moving_average_inverse_pkg::*;

  logic clk = 1'b0;
  logic reset, clear, in_valid, in_ready, out_valid, out_ready, overflow;
  logic [SIZE_WIN-1:0]         window_size;
  logic signed [SIZE_SUM-1:0]  in_sum;
  logic signed [SIZE_DATA-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int xs[256];
  int nx;

  typedef struct {
    int ws;
    bit restart;
    int sum;
    int exp;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  moving_average_inverse dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .window_size (window_size),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int ws);
    window_size = SIZE_WIN'(ws);
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst overflow", overflow, 0);
    chk("rst in_ready", in_ready, 1);
  endtask

  task automatic send(input int sum, input int exp, input string name);
    in_valid = 1'b1;
    in_sum   = SIZE_SUM'(sum);
    @(posedge clk);
    #1;
    chk({name, " valid"}, out_valid, 1);
    chk(name, out_data, exp);
  endtask

  // Sum-encode xs[0..nx-1] with window n_eff and expect each sample back.
  task automatic run_stream(input int n_eff, input string name);
    for (int i = 0; i < nx; i++) begin
      int s = 0;
      for (int k = ((i - n_eff + 1) > 0 ? (i - n_eff + 1) : 0); k <= i; k++) s += xs[k];
      send(s, xs[i], $sformatf("%s[%0d]", name, i));
    end
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int cnt);
    logic signed [15:0] r;
    nx = cnt;
    for (int i = 0; i < cnt; i++) begin
      r = 16'($urandom);
      xs[i] = r;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4, 1'b1, 1, 1};
    vecs[1]  = '{4, 1'b0, 3, 2};
    vecs[2]  = '{4, 1'b0, 6, 3};
    vecs[3]  = '{4, 1'b0, 10, 4};
    vecs[4]  = '{4, 1'b0, 14, 5};
    vecs[5]  = '{4, 1'b0, 18, 6};
    vecs[6]  = '{1, 1'b1, -5, -5};
    vecs[7]  = '{1, 1'b0, 7, 7};
    vecs[8]  = '{1, 1'b0, 0, 0};
    vecs[9]  = '{0, 1'b1, -5, -5};
    vecs[10] = '{0, 1'b0, 7, 7};
    vecs[11] = '{0, 1'b0, 0, 0};
    vecs[12] = '{1, 1'b1, -40000, -32768};
    vecs[13] = '{1, 1'b0, 0, 7232};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].restart) begin
        in_valid = 1'b0;
        do_reset(vecs[i].ws);
      end
      send(vecs[i].sum, vecs[i].exp, $sformatf("vec%0d", i));
    end
    in_valid = 1'b0;

    // Backpressure: three stalled cycles, nothing lost or repeated.
    do_reset(4);
    send(1, 1, "stall0");
    send(3, 2, "stall1");
    in_sum    = SIZE_SUM'(6);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall hold valid", out_valid, 1);
      chk("stall hold data", out_data, 2);
    end
    out_ready = 1'b1;
    send(6, 3, "stall2");
    send(10, 4, "stall3");
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("stall drain", out_valid, 0);

    // Positive saturation and sticky overflow, kept across clear.
    do_reset(2);
    send(32767, 32767, "sat0");
    chk("sat0 ovf", overflow, 0);
    send(65634, 32767, "sat1");
    chk("sat1 ovf", overflow, 1);
    send(65634, 32767, "sat2");
    chk("sat2 ovf sticky", overflow, 1);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("ovf kept by clear", overflow, 1);
    chk("clear out_valid", out_valid, 0);

    // Clear with window change; simultaneous input is dropped.
    do_reset(4);
    nx = 10;
    for (int i = 0; i < nx; i++) xs[i] = i + 1;
    run_stream(4, "pre");
    window_size = SIZE_WIN'(8);
    clear       = 1'b1;
    in_valid    = 1'b1;
    in_sum      = SIZE_SUM'(999);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear drop valid", out_valid, 0);
    chk("clear data", out_data, 0);
    nx = 12;
    for (int i = 0; i < nx; i++) xs[i] = i * 37 - 200;
    run_stream(8, "n8");

    // Full-depth random streams, including an oversize window clamped to max.
    do_reset(64);
    fill_random(200);
    run_stream(64, "rnd");
    do_reset(100);
    fill_random(80);
    run_stream(64, "clamp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
